// File: rtl/cpu_core_param_if.sv
// Memory bus between the core (master) and the system memory (slave).
// One request outstanding at a time; the slave completes it by raising mem_ready.
interface cpu_core_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core: FETCH -> EXEC (-> MEM) -> FETCH, with a HALT sink.
// Registers carry a zero flag each; a ready-handshaked memory port tolerates wait states.
module cpu_core_param #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       NREGS    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  cpu_core_param_if.master bus,
  output logic             o_halted
);

  // Working width for sub-word manipulation so DATA_W=16 can still address bits [31:16].
  localparam int unsigned XW = (DATA_W > 32) ? DATA_W : 32;

  localparam logic [5:0] OpAdd  = 6'd1;
  localparam logic [5:0] OpSub  = 6'd2;
  localparam logic [5:0] OpAnd  = 6'd3;
  localparam logic [5:0] OpOr   = 6'd4;
  localparam logic [5:0] OpXor  = 6'd5;
  localparam logic [5:0] OpLi   = 6'd6;
  localparam logic [5:0] OpSt   = 6'd7;
  localparam logic [5:0] OpLd   = 6'd8;
  localparam logic [5:0] OpJmp  = 6'd9;
  localparam logic [5:0] OpBz   = 6'd10;
  localparam logic [5:0] OpHalt = 6'd63;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e            r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, w_pc_d;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_flags;

  logic [5:0]  w_op;
  logic [2:0]  w_ra, w_rb, w_rd;
  logic        w_hl;
  logic [15:0] w_imm;

  assign w_op  = r_ir[5:0];
  assign w_ra  = r_ir[8:6];
  assign w_rb  = r_ir[11:9];
  assign w_rd  = r_ir[14:12];
  assign w_hl  = r_ir[15];
  assign w_imm = r_ir[31:16];

  logic [DATA_W-1:0] w_ra_val, w_rb_val, w_rd_val;
  logic              w_ra_flag;

  // Register/flag read ports; indices with no backing register read as zero, flag clear.
  always_comb begin
    w_ra_val  = '0;
    w_rb_val  = '0;
    w_rd_val  = '0;
    w_ra_flag = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (w_ra == 3'(i)) begin
        w_ra_val  = r_regs[i];
        w_ra_flag = r_flags[i];
      end
      if (w_rb == 3'(i)) w_rb_val = r_regs[i];
      if (w_rd == 3'(i)) w_rd_val = r_regs[i];
    end
  end

  logic [XW-1:0]     w_li_tmp;
  logic [DATA_W-1:0] w_li_hi;
  logic [XW-1:0]     w_rdata_ext;

  // LI with hl=1 replaces bits [31:16] of rd and keeps the rest.
  always_comb begin
    w_li_tmp        = XW'(w_rd_val);
    w_li_tmp[31:16] = w_imm;
  end
  assign w_li_hi     = w_li_tmp[DATA_W-1:0];
  assign w_rdata_ext = XW'(bus.mem_rdata);

  logic              w_ir_load;
  logic              w_req, w_we, w_halt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_wr_val;

  // Next-state, datapath control and bus outputs.
  always_comb begin
    w_next_state = r_state;
    w_pc_d       = r_pc;
    w_ir_load    = 1'b0;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = r_pc;
    w_wdata      = '0;
    w_halt       = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_val     = '0;
    unique case (r_state)
      StFetch: begin
        w_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_load    = 1'b1;
          w_pc_d       = r_pc + ADDR_W'(1);
          w_next_state = StExec;
        end
      end
      StExec: begin
        w_next_state = StFetch;
        case (w_op)
          OpAdd: begin w_wr_en = 1'b1; w_wr_val = w_ra_val + w_rb_val; end
          OpSub: begin w_wr_en = 1'b1; w_wr_val = w_ra_val - w_rb_val; end
          OpAnd: begin w_wr_en = 1'b1; w_wr_val = w_ra_val & w_rb_val; end
          OpOr:  begin w_wr_en = 1'b1; w_wr_val = w_ra_val | w_rb_val; end
          OpXor: begin w_wr_en = 1'b1; w_wr_val = w_ra_val ^ w_rb_val; end
          OpLi: begin
            w_wr_en  = 1'b1;
            w_wr_val = w_hl ? w_li_hi : DATA_W'(w_imm);
          end
          OpSt, OpLd: w_next_state = StMem;
          OpJmp:      w_pc_d = ADDR_W'(w_imm);
          OpBz:       if (w_ra_flag) w_pc_d = ADDR_W'(w_imm);
          OpHalt:     w_next_state = StHalt;
          default: ;
        endcase
      end
      StMem: begin
        w_req  = 1'b1;
        w_addr = ADDR_W'(w_ra_val);
        if (w_op == OpSt) begin
          w_we    = 1'b1;
          w_wdata = w_rb_val;
        end
        if (bus.mem_ready) begin
          w_next_state = StFetch;
          if (w_op == OpLd) begin
            w_wr_en  = 1'b1;
            w_wr_val = bus.mem_rdata;
          end
        end
      end
      StHalt:  w_halt = 1'b1;
      default: w_next_state = StFetch;
    endcase
    // Outputs are forced quiet while reset is held, independent of the stale state.
    if (i_reset) begin
      w_req   = 1'b0;
      w_we    = 1'b0;
      w_wdata = '0;
      w_halt  = 1'b0;
    end
  end

  assign bus.mem_req   = w_req;
  assign bus.mem_we    = w_we;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;
  assign o_halted      = w_halt;

  // State, PC and instruction register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StFetch;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_d;
      if (w_ir_load) r_ir <= w_rdata_ext[31:0];
    end
  end

  // Register file and zero flags; writes to indices without a register match nothing.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_flags <= '0;
    end else if (w_wr_en) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (w_rd == 3'(i)) begin
          r_regs[i]  <= w_wr_val;
          r_flags[i] <= (w_wr_val == '0);
        end
      end
    end
  end

endmodule
